// File: rtl/ay_bus_master.sv
// ay_bus_master: TurboSound AY/YM bus initiator; turns one register request into SEL/ADDR/WR|RD phases.
// Optional feature: define AYBUS_SEL_CACHE_EN to skip SEL when the target chip is already selected.
module ay_bus_master #(
  parameter int PHASE_LEN = 2,
  parameter int GAP_LEN   = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_CHIP,
  input  logic       REQ_WR,
  input  logic [3:0] REQ_REG,
  input  logic [7:0] REQ_DATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       BUSY,
  output logic       BDIR,
  output logic       BC,
  output logic [7:0] DO,
  input  logic [7:0] PSG_DI
);

  localparam int MAX_LEN = (PHASE_LEN > GAP_LEN) ? PHASE_LEN : GAP_LEN;
  localparam int CNT_W   = ($clog2(MAX_LEN) > 2) ? $clog2(MAX_LEN) : 2;
  localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(PHASE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_ADDR,
    ST_WR,
    ST_RD,
    ST_GAP
  } state_t;

  state_t           state, state_nx, prev_ph;
  logic [CNT_W-1:0] cnt;
  logic             chip_q, wr_q, sel_cache;
  logic [3:0]       reg_q;
  logic [7:0]       data_q;
  logic             need_sel;
  logic             cur_chip;
  logic [3:0]       cur_reg;
  logic [7:0]       cur_data;
  logic             bdir_nx, bc_nx;
  logic [7:0]       do_nx;
  logic             rd_done;

  // Phase that follows a completed phase (or the phase preceding a gap).
  function automatic state_t phase_after(input state_t ph, input logic wr);
    case (ph)
      ST_SEL:  return ST_ADDR;
      ST_ADDR: return wr ? ST_WR : ST_RD;
      default: return ST_IDLE;
    endcase
  endfunction

`ifdef AYBUS_SEL_CACHE_EN
  assign need_sel = (REQ_CHIP != sel_cache);
`else
  // Select is always issued; the cache term is kept only so the tracked state stays live.
  assign need_sel = (REQ_CHIP != sel_cache) | 1'b1;
`endif

  assign REQ_READY = (state == ST_IDLE);
  assign BUSY      = (state != ST_IDLE);
  assign rd_done   = (state == ST_RD) && (cnt == PH_LAST);

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    cur_chip = chip_q;
    cur_reg  = reg_q;
    cur_data = data_q;
    bdir_nx  = 1'b0;
    bc_nx    = 1'b0;
    do_nx    = 8'h00;

    // On the accept edge the latches are not loaded yet, so the first phase uses the live request.
    if (state == ST_IDLE) begin
      cur_chip = REQ_CHIP;
      cur_reg  = REQ_REG;
      cur_data = REQ_DATA;
    end

    case (state)
      ST_IDLE: if (REQ_VALID) state_nx = need_sel ? ST_SEL : ST_ADDR;
      ST_GAP:  if (cnt == GAP_LAST) state_nx = phase_after(prev_ph, wr_q);
      default: if (cnt == PH_LAST) state_nx = (GAP_LEN > 0) ? ST_GAP : phase_after(state, wr_q);
    endcase

    case (state_nx)
      ST_SEL: begin
        bdir_nx = 1'b1;
        bc_nx   = 1'b1;
        do_nx   = {7'h7F, cur_chip};
      end
      ST_ADDR: begin
        bdir_nx = 1'b1;
        bc_nx   = 1'b1;
        do_nx   = {4'h0, cur_reg};
      end
      ST_WR: begin
        bdir_nx = 1'b1;
        do_nx   = cur_data;
      end
      ST_RD:   bc_nx = 1'b1;
      ST_GAP:  do_nx = DO;
      default: ;
    endcase
  end

  // Bus pins are registered from the next state so they are glitch-free and change on phase boundaries.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      prev_ph   <= ST_IDLE;
      cnt       <= '0;
      chip_q    <= 1'b0;
      wr_q      <= 1'b0;
      reg_q     <= 4'h0;
      data_q    <= 8'h00;
      sel_cache <= 1'b1;
      BDIR      <= 1'b0;
      BC        <= 1'b0;
      DO        <= 8'h00;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= 8'h00;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? '0 : cnt + CNT_W'(1);

      if (state == ST_IDLE && REQ_VALID) begin
        chip_q <= REQ_CHIP;
        wr_q   <= REQ_WR;
        reg_q  <= REQ_REG;
        data_q <= REQ_DATA;
      end

      if (state != ST_GAP && state_nx == ST_GAP) prev_ph <= state;
      if (state == ST_SEL && state_nx != ST_SEL) sel_cache <= chip_q;

      RSP_VALID <= rd_done;
      if (rd_done) RSP_DATA <= PSG_DI;

      BDIR <= bdir_nx;
      BC   <= bc_nx;
      DO   <= do_nx;
    end
  end

endmodule

// File: tb/tb_ay_bus_master.sv
// tb_ay_bus_master: directed bench for ay_bus_master; one instance at P=2/G=1, one at P=1/G=0.
// Expectations follow AYBUS_SEL_CACHE_EN as defined (or not) for the build.
module tb_ay_bus_master;

`ifdef AYBUS_SEL_CACHE_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET;
  logic       req_valid, req_chip, req_wr;
  logic [3:0] req_reg;
  logic [7:0] req_data, psg_di;
  logic       use_b;

  logic       a_ready, a_rsp_valid, a_busy, a_bdir, a_bc;
  logic [7:0] a_rsp_data, a_do;
  logic       b_ready, b_rsp_valid, b_busy, b_bdir, b_bc;
  logic [7:0] b_rsp_data, b_do;

  logic       obs_ready, obs_rsp_valid, obs_busy, obs_bdir, obs_bc;
  logic [7:0] obs_rsp_data, obs_do;

  int n_pass  = 0;
  int n_total = 0;
  int cur_p   = 2;
  int cur_g   = 1;

  always #5 CLK = ~CLK;

  ay_bus_master #(.PHASE_LEN(2), .GAP_LEN(1)) u_a (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(req_valid & ~use_b), .REQ_READY(a_ready),
    .REQ_CHIP(req_chip), .REQ_WR(req_wr), .REQ_REG(req_reg), .REQ_DATA(req_data),
    .RSP_VALID(a_rsp_valid), .RSP_DATA(a_rsp_data), .BUSY(a_busy),
    .BDIR(a_bdir), .BC(a_bc), .DO(a_do), .PSG_DI(psg_di)
  );

  ay_bus_master #(.PHASE_LEN(1), .GAP_LEN(0)) u_b (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(req_valid & use_b), .REQ_READY(b_ready),
    .REQ_CHIP(req_chip), .REQ_WR(req_wr), .REQ_REG(req_reg), .REQ_DATA(req_data),
    .RSP_VALID(b_rsp_valid), .RSP_DATA(b_rsp_data), .BUSY(b_busy),
    .BDIR(b_bdir), .BC(b_bc), .DO(b_do), .PSG_DI(psg_di)
  );

  assign obs_ready     = use_b ? b_ready     : a_ready;
  assign obs_rsp_valid = use_b ? b_rsp_valid : a_rsp_valid;
  assign obs_rsp_data  = use_b ? b_rsp_data  : a_rsp_data;
  assign obs_busy      = use_b ? b_busy      : a_busy;
  assign obs_bdir      = use_b ? b_bdir      : a_bdir;
  assign obs_bc        = use_b ? b_bc        : a_bc;
  assign obs_do        = use_b ? b_do        : a_do;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issues one request from an IDLE cycle and walks every cycle until the block is IDLE again.
  task automatic do_req(input logic chip, input logic wr, input logic [3:0] rg,
                        input logic [7:0] dat, input logic sel_exp, input logic [7:0] di);
    logic [1:0] ph_bus [3];
    logic [7:0] ph_do  [3];
    int n;
    check("ready_before_req", {obs_ready, obs_busy}, 2'b10);
    req_valid = 1'b1;
    req_chip  = chip;
    req_wr    = wr;
    req_reg   = rg;
    req_data  = dat;
    @(negedge CLK);
    // Scramble the request fields; the block must use what it latched.
    req_valid = 1'b0;
    req_chip  = ~chip;
    req_wr    = ~wr;
    req_reg   = ~rg;
    req_data  = ~dat;
    n = 0;
    if (sel_exp) begin
      ph_bus[n] = 2'b11;
      ph_do[n]  = {7'h7F, chip};
      n++;
    end
    ph_bus[n] = 2'b11;
    ph_do[n]  = {4'h0, rg};
    n++;
    ph_bus[n] = wr ? 2'b10 : 2'b01;
    ph_do[n]  = wr ? dat : 8'h00;
    n++;
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < cur_p; c++) begin
        check("phase_bus", {obs_bdir, obs_bc, obs_do}, {ph_bus[p], ph_do[p]});
        check("phase_busy", {obs_ready, obs_busy, obs_rsp_valid}, 3'b010);
        if (!wr && p == n - 1) psg_di = (c == cur_p - 1) ? di : 8'hE1;
        @(negedge CLK);
      end
      if (!wr && p == n - 1) begin
        check("rsp_pulse", {obs_rsp_valid, obs_rsp_data}, {1'b1, di});
      end
      for (int g = 0; g < cur_g; g++) begin
        check("gap_bus", {obs_bdir, obs_bc, obs_do}, {2'b00, ph_do[p]});
        check("gap_busy", {obs_ready, obs_busy}, 2'b01);
        if (g > 0 || wr || p != n - 1) check("gap_no_rsp", obs_rsp_valid, 1'b0);
        @(negedge CLK);
      end
    end
    check("idle_after", {obs_ready, obs_busy, obs_bdir, obs_bc, obs_do}, {4'b1000, 8'h00});
    if (wr || cur_g > 0) check("idle_no_rsp", obs_rsp_valid, 1'b0);
    psg_di = 8'h00;
  endtask

  initial begin
    RESET     = 1'b1;
    req_valid = 1'b0;
    req_chip  = 1'b0;
    req_wr    = 1'b0;
    req_reg   = 4'h0;
    req_data  = 8'h00;
    psg_di    = 8'h00;
    use_b     = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_a", {a_ready, a_busy, a_bdir, a_bc, a_do, a_rsp_valid, a_rsp_data},
          {4'b1000, 8'h00, 1'b0, 8'h00});
    check("reset_b", {b_ready, b_busy, b_bdir, b_bc, b_do, b_rsp_valid, b_rsp_data},
          {4'b1000, 8'h00, 1'b0, 8'h00});
    RESET = 1'b0;
    @(negedge CLK);

    // Instance A: PHASE_LEN=2, GAP_LEN=1. Reset cache points at chip 1.
    do_req(1'b1, 1'b1, 4'd7,  8'h38, !CE,  8'h00);
    do_req(1'b0, 1'b1, 4'd0,  8'hAA, 1'b1, 8'h00);
    do_req(1'b0, 1'b0, 4'd3,  8'h00, !CE,  8'h3C);
    do_req(1'b1, 1'b0, 4'd14, 8'h00, 1'b1, 8'h5C);
    repeat (3) @(negedge CLK);
    check("rsp_data_held", {obs_rsp_valid, obs_rsp_data}, {1'b0, 8'h5C});
    do_req(1'b0, 1'b1, 4'd8,  8'h0F, 1'b1, 8'h00);
    check("rsp_held_after_wr", obs_rsp_data, 8'h5C);

    // Abort a write to chip 0 in its WR phase; the cache must fall back to chip 1.
    req_valid = 1'b1;
    req_chip  = 1'b0;
    req_wr    = 1'b1;
    req_reg   = 4'd9;
    req_data  = 8'h10;
    @(negedge CLK);
    req_valid = 1'b0;
    repeat (CE ? 3 : 6) @(negedge CLK);
    check("abort_in_wr", {obs_bdir, obs_bc, obs_do}, {2'b10, 8'h10});
    RESET = 1'b1;
    @(negedge CLK);
    check("abort_bus_idle", {obs_ready, obs_busy, obs_bdir, obs_bc, obs_do, obs_rsp_valid},
          {4'b1000, 8'h00, 1'b0});
    RESET = 1'b0;
    @(negedge CLK);
    check("abort_stays_idle", {obs_ready, obs_bdir, obs_bc, obs_rsp_valid}, 4'b1000);
    do_req(1'b0, 1'b1, 4'd1,  8'h77, 1'b1, 8'h00);

    // Instance B: PHASE_LEN=1, GAP_LEN=0.
    use_b = 1'b1;
    cur_p = 1;
    cur_g = 0;
    do_req(1'b1, 1'b0, 4'd5,  8'h00, !CE,  8'hA5);
    @(negedge CLK);
    check("b_rsp_single", {obs_rsp_valid, obs_rsp_data}, {1'b0, 8'hA5});
    do_req(1'b0, 1'b1, 4'd2,  8'h09, 1'b1, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
